bcd_digit_prep: RTL and testbench
=================================

Name: bcd_digit_prep

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display driver.
- Captures the current PC, the x5 register value and the halt flag from the RISC-V datapath.
- Converts the two binary values to two decimal digits each using iterative double-dabble, one bit per cycle.
- Presents the five 4-bit digit codes the display stage decodes; code 4'hF is the display's blank code.

Parameters:
- IN_WIDTH, 8, bit width of pc_in and x5_in; legal range 4..8; BCD scratch is always 3 nibbles (12 bits).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new conversion; sampled only in IDLE
- pc_in  input  IN_WIDTH  binary program counter value
- x5_in  input  IN_WIDTH  binary x5 register value
- halt_in  input  1  processor finished flag
- busy  output  1  high while a conversion is in progress (SHIFT or LATCH)
- done  output  1  one-cycle pulse when new digits are valid
- pc1  output  4  PC tens digit
- pc2  output  4  PC units digit
- x5part1  output  4  x5 tens digit
- x5part2  output  4  x5 units digit
- final  output  4  4'd1 if captured halt_in=1, else 4'd0

Behaviour:
- Reset is synchronous: reset high at a clock edge forces the following, regardless of current state:
  - state=IDLE, busy=0, done=0, bit counter=0, BCD scratch cleared.
  - pc1, pc2, x5part1 and x5part2 = 4'hF (blank); final=4'd0.
- Reset mid-conversion aborts the conversion. Captured operands are discarded; no done is produced.
- States:
  - IDLE: if start=1 at edge k, capture pc_in, x5_in and halt_in into shift registers; clear both 12-bit BCD scratches; load counter=IN_WIDTH; go to SHIFT. Otherwise hold.
  - SHIFT: each cycle, for both PC and x5 in parallel, first add 3 to every BCD nibble that is >=5, then shift {bcd, bin} left by 1 bit. Decrement the counter. Once IN_WIDTH shifts are done, go to LATCH.
  - LATCH: register the output digits, assert done=1 for one cycle, return to IDLE.
- Output digit rules, applied independently to PC and x5:
  - Hundreds nibble == 0: tens/units digits = BCD nibbles [7:4] and [3:0].
  - Hundreds nibble != 0 (value >99): overflow handling as given under Optional Feature.
- final = 4'd1 if the captured halt_in=1, else 4'd0.
- Latency: start sampled at edge k means SHIFT occupies edges k+1..k+IN_WIDTH. Outputs and done update at edge k+IN_WIDTH+1; done is visible during the following cycle.
- Total start-to-done: IN_WIDTH+1 edges (9 at default).
- busy=1 from edge k+1 up to and including the LATCH edge; busy is 0 in the cycle done is high.
- start while busy=1 is ignored and not queued.
- start in the same cycle that done is high is accepted, since the block is in IDLE.
- Output digits hold their last value between conversions; they never show intermediate scratch values.
- Inputs are sampled only at the start edge. Changes during conversion have no effect.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined: a value >99 saturates, giving tens=4'd9 and units=4'd9.
- Undefined: a value >99 gives tens=4'hF and units=4'hF, so the display stage blanks both digits.
- final is unaffected either way.

Test Plan:
- Reset, then start with pc_in=42, x5_in=7, halt_in=0 -> done exactly 9 edges after the start edge; pc1=4, pc2=2, x5part1=0, x5part2=7, final=0; busy high for exactly 9 cycles.
- pc_in=99, x5_in=0, halt_in=1 -> pc1=9, pc2=9, x5part1=0, x5part2=0, final=1.
- pc_in=100, x5_in=255:
  - macro undefined -> all four digits 4'hF.
  - BCD_SATURATE_EN defined -> all four digits 4'd9.
- Pulse start again 3 cycles into a conversion with different operands -> ignored; a single done appears carrying the first operands' digits.
- Assert reset 4 cycles into a conversion -> next cycle busy=0, no done pulse, digits=4'hF, final=0; a new start then completes normally.
- Start asserted in the done cycle with pc_in=5 -> second conversion accepted; second done 9 edges later; pc1=0, pc2=5.

Source files
------------

// File: rtl/bcd_digit_prep.sv
// bcd_digit_prep: double-dabble PC and x5 into two BCD digits each for the seven-segment stage.
// Define BCD_SATURATE_EN to show 99 for values above 99 instead of blank digits.
module bcd_digit_prep #(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] pc_in,
  input  logic [IN_WIDTH-1:0] x5_in,
  input  logic                halt_in,
  output logic                busy,
  output logic                done,
  output logic [3:0]          pc1,
  output logic [3:0]          pc2,
  output logic [3:0]          x5part1,
  output logic [3:0]          x5part2,
  output logic [3:0]          final_digit
);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
`ifdef BCD_SATURATE_EN
  localparam logic [3:0] OVF = 4'd9;
`else
  localparam logic [3:0] OVF = 4'hF;
`endif
  localparam logic [3:0] CNT_INIT = 4'(IN_WIDTH);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [IN_WIDTH-1:0] pc_bin, x5_bin;
  logic [11:0] pc_bcd, x5_bcd;
  logic halt_q;
  function automatic logic [11:0] adj(input logic [11:0] b);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction
  function automatic logic [3:0] dig(input logic [11:0] b, input logic tens);
    return b[11:8] != 4'd0 ? OVF : tens ? b[7:4] : b[3:0];
  endfunction
  assign busy = state != IDLE;
  always_comb begin
    nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
          state == SHIFT ? (cnt == 4'd1 ? LATCH : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pc_bin      <= '0;
      x5_bin      <= '0;
      pc_bcd      <= '0;
      x5_bcd      <= '0;
      halt_q      <= 1'b0;
      done        <= 1'b0;
      pc1         <= 4'hF;
      pc2         <= 4'hF;
      x5part1     <= 4'hF;
      x5part2     <= 4'hF;
      final_digit <= 4'd0;
    end else begin
      state <= nxt;
      done  <= state == LATCH;
      if (state == IDLE && start) begin
        pc_bin <= pc_in;
        x5_bin <= x5_in;
        halt_q <= halt_in;
        pc_bcd <= '0;
        x5_bcd <= '0;
        cnt    <= CNT_INIT;
      end
      if (state == SHIFT) begin
        {pc_bcd, pc_bin} <= {adj(pc_bcd), pc_bin} << 1;
        {x5_bcd, x5_bin} <= {adj(x5_bcd), x5_bin} << 1;
        cnt <= cnt - 4'd1;
      end
      if (state == LATCH) begin
        pc1         <= dig(pc_bcd, 1'b1);
        pc2         <= dig(pc_bcd, 1'b0);
        x5part1     <= dig(x5_bcd, 1'b1);
        x5part2     <= dig(x5_bcd, 1'b0);
        final_digit <= {3'b000, halt_q};
      end
    end
  end
endmodule

// File: tb/tb_bcd_digit_prep.sv
// tb_bcd_digit_prep: randomized and directed checks of bcd_digit_prep against a decimal model.
module tb_bcd_digit_prep;
  logic clk = 0, reset = 0, start = 0, halt_in = 0;
  logic [7:0] pc_in = 0, x5_in = 0;
  logic busy, done;
  logic [3:0] pc1, pc2, x5part1, x5part2, final_digit;
  int total = 0, bad = 0;
`ifdef BCD_SATURATE_EN
  localparam logic [3:0] OVF = 4'd9;
`else
  localparam logic [3:0] OVF = 4'hF;
`endif
  bcd_digit_prep #(.IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .x5_in(x5_in), .halt_in(halt_in),
    .busy(busy), .done(done), .pc1(pc1), .pc2(pc2), .x5part1(x5part1), .x5part2(x5part2),
    .final_digit(final_digit)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input int p, input int x);
    logic [3:0] a, b, c, d;
    a = p > 99 ? OVF : 4'(p / 10);
    b = p > 99 ? OVF : 4'(p % 10);
    c = x > 99 ? OVF : 4'(x / 10);
    d = x > 99 ? OVF : 4'(x % 10);
    return {a, b, c, d};
  endfunction
  // call at a negedge; returns at the negedge where done is seen (lat=0 if never)
  task automatic run_conv(input int p, input int x, input logic h, output int lat, output int bc);
    pc_in = 8'(p); x5_in = 8'(x); halt_in = h; start = 1;
    lat = 0; bc = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == 0) start = 0;
      if (busy) bc++;
      if (done) begin lat = j; break; end
    end
  endtask
  task automatic check_conv(input string nm, input int p, input int x, input logic h);
    logic [15:0] e;
    e = model(p, x);
    total++;
    if ({pc1, pc2, x5part1, x5part2} !== e || final_digit !== {3'b0, h}) begin
      bad++;
      $display("FAIL %s: digits=%h final=%0d expected digits=%h final=%0d", nm,
               {pc1, pc2, x5part1, x5part2}, final_digit, e, h);
    end
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    total++;
    if (busy !== 0 || done !== 0 || {pc1, pc2, x5part1, x5part2} !== 16'hFFFF || final_digit !== 0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b digits=%h final=%0d expected 0 0 ffff 0",
               busy, done, {pc1, pc2, x5part1, x5part2}, final_digit);
    end
  endtask
  task automatic test_basic;
    int lat, bc;
    @(negedge clk);
    run_conv(42, 7, 0, lat, bc);
    total++;
    if (lat !== 9 || bc !== 9) begin
      bad++;
      $display("FAIL basic_timing: latency=%0d busy_cycles=%0d expected 9 9", lat, bc);
    end
    check_conv("basic_42_7", 42, 7, 0);
    @(negedge clk);
    total++;
    if (done !== 0) begin bad++; $display("FAIL done_pulse: done=%b expected 0", done); end
    run_conv(99, 0, 1, lat, bc);
    check_conv("edge_99_0", 99, 0, 1);
    @(negedge clk);
    run_conv(100, 255, 0, lat, bc);
    check_conv("overflow_100_255", 100, 255, 0);
  endtask
  task automatic test_random;
    int lat, bc, p, x;
    logic h;
    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(0, 255)); x = int'($urandom_range(0, 255)); h = 1'($urandom);
      @(negedge clk);
      run_conv(p, x, h, lat, bc);
      total++;
      if (lat !== 9) begin bad++; $display("FAIL rand_latency: latency=%0d expected 9", lat); end
      check_conv("random", p, x, h);
    end
  endtask
  task automatic test_ignore_start;
    int dones = 0;
    @(negedge clk);
    pc_in = 12; x5_in = 34; halt_in = 1; start = 1;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      start = j == 3;
      if (j == 3) begin pc_in = 56; x5_in = 78; halt_in = 0; end
      if (done) dones++;
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL ignore_start: done_count=%0d expected 1", dones); end
    check_conv("ignore_start", 12, 34, 1);
  endtask
  task automatic test_reset_mid;
    int lat, bc, dones = 0;
    @(negedge clk);
    pc_in = 88; x5_in = 88; halt_in = 1; start = 1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      start = 0;
      reset = j == 3;
    end
    @(negedge clk);
    reset = 0;
    total++;
    if (busy !== 0 || done !== 0 || {pc1, pc2, x5part1, x5part2} !== 16'hFFFF || final_digit !== 0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b digits=%h final=%0d expected 0 0 ffff 0",
               busy, done, {pc1, pc2, x5part1, x5part2}, final_digit);
    end
    repeat (12) begin @(negedge clk); if (done) dones++; end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL reset_mid_done: done_count=%0d expected 0", dones); end
    run_conv(23, 45, 0, lat, bc);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL after_reset_latency: latency=%0d expected 9", lat); end
    check_conv("after_reset", 23, 45, 0);
  endtask
  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clk);
    run_conv(11, 22, 1, lat, bc);
    check_conv("b2b_first", 11, 22, 1);
    run_conv(5, 3, 0, lat, bc);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL b2b_latency: latency=%0d expected 9", lat); end
    check_conv("b2b_second", 5, 3, 0);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_random;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
